// File: rtl/mux_8way_16.sv
// 8-input word multiplexer with a combinational output and an enabled,
// asynchronously cleared registered copy of the selected word.
module mux_8way_16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i7,
  input  logic [WIDTH-1:0] i6,
  input  logic [WIDTH-1:0] i5,
  input  logic [WIDTH-1:0] i4,
  input  logic [WIDTH-1:0] i3,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i0,
  input  logic [2:0]       sel,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q
);

  // Tree levels: pairs (sel[0]), quads (sel[1]), halves (sel[2]).
  logic [WIDTH-1:0] pair_10, pair_32, pair_54, pair_76;
  logic [WIDTH-1:0] quad_lo, quad_hi;
  logic [WIDTH-1:0] out_reg_d, out_reg_q;

  // First level: choose within each pair of inputs.
  always_comb begin
    pair_10 = sel[0] ? i1 : i0;
    pair_32 = sel[0] ? i3 : i2;
    pair_54 = sel[0] ? i5 : i4;
    pair_76 = sel[0] ? i7 : i6;
  end

  // Second level: choose within each quad.
  always_comb begin
    quad_lo = sel[1] ? pair_32 : pair_10;
    quad_hi = sel[1] ? pair_76 : pair_54;
  end

  // Final level: sel[2] picks the upper half.
  always_comb begin
    out = sel[2] ? quad_hi : quad_lo;
  end

  // Load the selected word when enabled, otherwise hold.
  always_comb begin
    out_reg_d = out_reg_q;
    if (en) begin
      out_reg_d = out;
    end
  end

  // Registered copy; reset clears it immediately, independent of clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_reg_q <= '0;
    end else begin
      out_reg_q <= out_reg_d;
    end
  end

  assign out_q = out_reg_q;

endmodule

// File: tb/tb_mux_8way_16.sv
// Directed bench for mux_8way_16: select sweep, data tracking, enabled
// register load/hold and asynchronous reset behaviour.
module tb_mux_8way_16;

  logic        clk;
  logic        rst;
  logic [15:0] i7, i6, i5, i4, i3, i2, i1, i0;
  logic [2:0]  sel;
  logic        en;
  logic [15:0] out;
  logic [15:0] out_q;

  int unsigned n_cmp;
  int unsigned n_bad;

  mux_8way_16 #(
    .WIDTH(16)
  ) u_dut (
    .clk  (clk),
    .rst  (rst),
    .i7   (i7),
    .i6   (i6),
    .i5   (i5),
    .i4   (i4),
    .i3   (i3),
    .i2   (i2),
    .i1   (i1),
    .i0   (i0),
    .sel  (sel),
    .en   (en),
    .out  (out),
    .out_q(out_q)
  );

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%04h, want 0x%04h", tag, obs, exp);
    end
  endtask

  // One clock pulse; outputs are sampled after the falling edge.
  task automatic tick();
    #2 clk = 1'b1;
    #2 clk = 1'b0;
    #1;
  endtask

  initial begin
    logic [15:0] sweep_exp [8];
    sweep_exp[0] = 16'h0100; sweep_exp[1] = 16'h0200;
    sweep_exp[2] = 16'h0400; sweep_exp[3] = 16'h0800;
    sweep_exp[4] = 16'h1000; sweep_exp[5] = 16'h2000;
    sweep_exp[6] = 16'h4000; sweep_exp[7] = 16'h8000;

    n_cmp = 0;
    n_bad = 0;
    clk = 1'b0;
    rst = 1'b1;
    en  = 1'b0;
    sel = 3'd0;
    i7 = 16'h8000; i6 = 16'h4000; i5 = 16'h2000; i4 = 16'h1000;
    i3 = 16'h0800; i2 = 16'h0400; i1 = 16'h0200; i0 = 16'h0100;
    #1;
    check_eq("reset_out_q", out_q, 16'h0000);
    rst = 1'b0;
    #1;

    // Select sweep with no clock activity.
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      #1;
      check_eq($sformatf("sweep_sel%0d", s), out, sweep_exp[s]);
    end
    check_eq("no_clk_out_q", out_q, 16'h0000);

    // Data tracking on sel=5; neighbours must not leak through.
    sel = 3'b101;
    i5 = 16'hFFFF;
    #1;
    check_eq("track_i5", out, 16'hFFFF);
    i4 = 16'h1234;
    i6 = 16'h5678;
    #1;
    check_eq("track_i4_i6_ignored", out, 16'hFFFF);
    i5 = 16'h2000; i4 = 16'h1000; i6 = 16'h4000;
    #1;

    // Load a nonzero value, then an async reset pulse must clear it.
    en = 1'b1;
    sel = 3'b010;
    tick();
    check_eq("preload_out_q", out_q, 16'h0400);
    rst = 1'b1;
    #1;
    check_eq("rst_pulse_out_q", out_q, 16'h0000);
    rst = 1'b0;
    #1;

    // Registered load and hold.
    en = 1'b1;
    sel = 3'b011;
    tick();
    check_eq("load_sel3", out_q, 16'h0800);
    en = 1'b0;
    sel = 3'b111;
    tick();
    check_eq("hold_out_q", out_q, 16'h0800);
    check_eq("hold_out", out, 16'h8000);
    en = 1'b1;
    tick();
    check_eq("load_sel7", out_q, 16'h8000);

    // Async reset between edges while out keeps tracking sel.
    #2 rst = 1'b1;
    #1;
    check_eq("midrun_rst_out_q", out_q, 16'h0000);
    sel = 3'b001;
    #1;
    check_eq("midrun_rst_out", out, 16'h0200);
    tick();
    check_eq("edge_in_rst_out_q", out_q, 16'h0000);
    rst = 1'b0;
    #1;
    check_eq("post_rst_out_q", out_q, 16'h0000);
    tick();
    check_eq("reload_out_q", out_q, 16'h0200);

    // Sel and data change together before an edge.
    sel = 3'b110;
    i6 = 16'hABCD;
    tick();
    check_eq("simul_out", out, 16'hABCD);
    check_eq("simul_out_q", out_q, 16'hABCD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
